instr_encoder_loader: RTL and testbench

//  Inverse of the control decoder: accepts symbolic instruction descriptors
//  (mnemonic + fields) over a valid/ready handshake and emits encoded 32-bit

---
 rtl/mips_isa_pkg.sv | 83 ++++++++
 rtl/instr_encode.sv | 52 +++++
 rtl/instr_encoder_loader.sv | 144 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: mnemonic enum, opcode/funct values and field-packing helpers.
// Used by the control decoder and by instr_encoder_loader / instr_encode.
package mips_isa_pkg;

   // Symbolic mnemonics; codes 26..31 are unassigned and treated as illegal.
   typedef enum logic [4:0] {
      MN_ADD   = 5'd0,
      MN_ADDU  = 5'd1,
      MN_SUB   = 5'd2,
      MN_SUBU  = 5'd3,
      MN_AND   = 5'd4,
      MN_OR    = 5'd5,
      MN_XOR   = 5'd6,
      MN_NOR   = 5'd7,
      MN_SLT   = 5'd8,
      MN_SLTU  = 5'd9,
      MN_SLL   = 5'd10,
      MN_SRL   = 5'd11,
      MN_SRA   = 5'd12,
      MN_ADDI  = 5'd13,
      MN_ADDIU = 5'd14,
      MN_ANDI  = 5'd15,
      MN_ORI   = 5'd16,
      MN_XORI  = 5'd17,
      MN_SLTI  = 5'd18,
      MN_SLTIU = 5'd19,
      MN_LUI   = 5'd20,
      MN_LW    = 5'd21,
      MN_SW    = 5'd22,
      MN_BEQ   = 5'd23,
      MN_BNE   = 5'd24,
      MN_J     = 5'd25
   } mnem_e;

   // Primary opcodes
   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_J     = 6'h02;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_BNE   = 6'h05;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_ADDIU = 6'h09;
   localparam logic [5:0] OPC_SLTI  = 6'h0A;
   localparam logic [5:0] OPC_SLTIU = 6'h0B;
   localparam logic [5:0] OPC_ANDI  = 6'h0C;
   localparam logic [5:0] OPC_ORI   = 6'h0D;
   localparam logic [5:0] OPC_XORI  = 6'h0E;
   localparam logic [5:0] OPC_LUI   = 6'h0F;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2B;

   // R-type function codes
   localparam logic [5:0] FUNCT_SLL  = 6'h00;
   localparam logic [5:0] FUNCT_SRL  = 6'h02;
   localparam logic [5:0] FUNCT_SRA  = 6'h03;
   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_ADDU = 6'h21;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_SUBU = 6'h23;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_XOR  = 6'h26;
   localparam logic [5:0] FUNCT_NOR  = 6'h27;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;
   localparam logic [5:0] FUNCT_SLTU = 6'h2B;

   // Loader FSM states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
      return {OPC_RTYPE, rs, rt, rd, shamt, funct};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {opc, rs, rt, imm};
   endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational descriptor -> 32-bit MIPS word encoder with legality flag.
module instr_encode
   import mips_isa_pkg::*;
(
   input  logic [4:0]  mnem,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        legal
);

   // Select format and code per mnemonic; unused fields are forced to zero.
   always_comb begin
      word  = 32'h0;
      legal = 1'b1;
      case (mnem_e'(mnem))
         MN_ADD:   word = enc_r(rs, rt, rd, 5'd0, FUNCT_ADD);
         MN_ADDU:  word = enc_r(rs, rt, rd, 5'd0, FUNCT_ADDU);
         MN_SUB:   word = enc_r(rs, rt, rd, 5'd0, FUNCT_SUB);
         MN_SUBU:  word = enc_r(rs, rt, rd, 5'd0, FUNCT_SUBU);
         MN_AND:   word = enc_r(rs, rt, rd, 5'd0, FUNCT_AND);
         MN_OR:    word = enc_r(rs, rt, rd, 5'd0, FUNCT_OR);
         MN_XOR:   word = enc_r(rs, rt, rd, 5'd0, FUNCT_XOR);
         MN_NOR:   word = enc_r(rs, rt, rd, 5'd0, FUNCT_NOR);
         MN_SLT:   word = enc_r(rs, rt, rd, 5'd0, FUNCT_SLT);
         MN_SLTU:  word = enc_r(rs, rt, rd, 5'd0, FUNCT_SLTU);
         // shifts take their operand from rt; rs is not part of the encoding
         MN_SLL:   word = enc_r(5'd0, rt, rd, shamt, FUNCT_SLL);
         MN_SRL:   word = enc_r(5'd0, rt, rd, shamt, FUNCT_SRL);
         MN_SRA:   word = enc_r(5'd0, rt, rd, shamt, FUNCT_SRA);
         MN_ADDI:  word = enc_i(OPC_ADDI, rs, rt, imm);
         MN_ADDIU: word = enc_i(OPC_ADDIU, rs, rt, imm);
         MN_ANDI:  word = enc_i(OPC_ANDI, rs, rt, imm);
         MN_ORI:   word = enc_i(OPC_ORI, rs, rt, imm);
         MN_XORI:  word = enc_i(OPC_XORI, rs, rt, imm);
         MN_SLTI:  word = enc_i(OPC_SLTI, rs, rt, imm);
         MN_SLTIU: word = enc_i(OPC_SLTIU, rs, rt, imm);
         MN_LUI:   word = enc_i(OPC_LUI, 5'd0, rt, imm);
         MN_LW:    word = enc_i(OPC_LW, rs, rt, imm);
         MN_SW:    word = enc_i(OPC_SW, rs, rt, imm);
         MN_BEQ:   word = enc_i(OPC_BEQ, rs, rt, imm);
         MN_BNE:   word = enc_i(OPC_BNE, rs, rt, imm);
         MN_J:     word = {OPC_J, target};
         default:  legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: takes symbolic instruction descriptors over valid/ready and writes
// encoded words to instruction memory at sequential word addresses starting at BASE_ADDR.
// Optional feature macro INSTR_LOADER_CHECKSUM_EN adds a running XOR checksum output.
module instr_encoder_loader
   import mips_isa_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned DEPTH     = 256,
   localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          op_valid,
   output logic          op_ready,
   input  logic [4:0]    op_mnem,
   input  logic [4:0]    op_rs,
   input  logic [4:0]    op_rt,
   input  logic [4:0]    op_rd,
   input  logic [4:0]    op_shamt,
   input  logic [15:0]   op_imm,
   input  logic [25:0]   op_target,
   input  logic          op_last,
   output logic          imem_we,
   output logic [31:0]   imem_addr,
   output logic [31:0]   imem_wdata,
   output logic [CW-1:0] word_count,
`ifdef INSTR_LOADER_CHECKSUM_EN
   output logic [31:0]   checksum,
`endif
   output logic          done,
   output logic          err
);

   localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);

   logic [1:0]  state_q, state_d;
   logic        accept, write_en, at_last_slot;
   logic [31:0] enc_word;
   logic        enc_legal;

   instr_encode u_encode (
      .mnem   (op_mnem),
      .rs     (op_rs),
      .rt     (op_rt),
      .rd     (op_rd),
      .shamt  (op_shamt),
      .imm    (op_imm),
      .target (op_target),
      .word   (enc_word),
      .legal  (enc_legal)
   );

   // Ready depends only on state and start so upstream can never see a valid->ready loop.
   assign op_ready     = (state_q == ST_LOAD) & ~start;
   assign accept       = op_valid & op_ready;
   assign write_en     = accept & enc_legal;
   assign at_last_slot = (word_count == CNT_LAST);

   // Next-state: start always (re)opens a session; an accept may close it.
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = ST_LOAD;
      end else if (accept) begin
         if (!enc_legal) begin
            state_d = ST_ERR;
         end else if (op_last) begin
            state_d = ST_DONE;
         end else if (at_last_slot) begin
            state_d = ST_ERR;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Write strobe and data, one cycle after the accept
   always_ff @(posedge clk) begin
      if (reset) begin
         imem_we    <= 1'b0;
         imem_wdata <= 32'h0;
      end else begin
         imem_we <= write_en;
         if (write_en) begin
            imem_wdata <= enc_word;
         end
      end
   end

   // Address holds the current write target and advances once that write has happened
   always_ff @(posedge clk) begin
      if (reset || start) begin
         imem_addr <= BASE_ADDR;
      end else if (imem_we) begin
         imem_addr <= imem_addr + 32'd4;
      end
   end

   // Word counter, counted at accept so it lines up with the write it describes
   always_ff @(posedge clk) begin
      if (reset || start) begin
         word_count <= '0;
      end else if (write_en && (word_count != CNT_MAX)) begin
         word_count <= word_count + CW'(1);
      end
   end

   // Sticky completion / error flags, cleared only by start or reset
   always_ff @(posedge clk) begin
      if (reset || start) begin
         done <= 1'b0;
         err  <= 1'b0;
      end else if (accept) begin
         if (!enc_legal) begin
            err <= 1'b1;
         end else if (op_last) begin
            done <= 1'b1;
         end else if (at_last_slot) begin
            err <= 1'b1;
         end
      end
   end

`ifdef INSTR_LOADER_CHECKSUM_EN
   // Running XOR of every word written this session, updated alongside imem_we
   always_ff @(posedge clk) begin
      if (reset || start) begin
         checksum <= 32'h0;
      end else if (write_en) begin
         checksum <= checksum ^ enc_word;
      end
   end
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: session-level behavioural model plus
// directed literal checks. Checks the checksum output when INSTR_LOADER_CHECKSUM_EN is set.
module tb_instr_encoder_loader;
   import mips_isa_pkg::*;

   localparam logic [31:0] BASE  = 32'h0000_0040;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0, reset = 1'b1, start = 1'b0, op_valid = 1'b0, op_last = 1'b0;
   logic [4:0]    op_mnem = '0, op_rs = '0, op_rt = '0, op_rd = '0, op_shamt = '0;
   logic [15:0]   op_imm = '0;
   logic [25:0]   op_target = '0;
   logic          op_ready, imem_we, done, err;
   logic [31:0]   imem_addr, imem_wdata;
   logic [CW-1:0] word_count;
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [31:0]   checksum;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   instr_encoder_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_mnem    (op_mnem),
      .op_rs      (op_rs),
      .op_rt      (op_rt),
      .op_rd      (op_rd),
      .op_shamt   (op_shamt),
      .op_imm     (op_imm),
      .op_target  (op_target),
      .op_last    (op_last),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .word_count (word_count),
`ifdef INSTR_LOADER_CHECKSUM_EN
      .checksum   (checksum),
`endif
      .done       (done),
      .err        (err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference encoding: {legal, word} from the ISA tables, written from scratch.
   function automatic logic [32:0] ref_enc(input logic [4:0] mn, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [4:0] sh, input logic [15:0] imm,
                                           input logic [25:0] tgt);
      int         kind;  // 0 illegal, 1 R, 2 shift, 3 I, 4 LUI, 5 J
      logic [5:0] code;
      kind = 0;
      code = 6'h00;
      case (mn)
         5'd0:  begin kind = 1; code = 6'h20; end
         5'd1:  begin kind = 1; code = 6'h21; end
         5'd2:  begin kind = 1; code = 6'h22; end
         5'd3:  begin kind = 1; code = 6'h23; end
         5'd4:  begin kind = 1; code = 6'h24; end
         5'd5:  begin kind = 1; code = 6'h25; end
         5'd6:  begin kind = 1; code = 6'h26; end
         5'd7:  begin kind = 1; code = 6'h27; end
         5'd8:  begin kind = 1; code = 6'h2A; end
         5'd9:  begin kind = 1; code = 6'h2B; end
         5'd10: begin kind = 2; code = 6'h00; end
         5'd11: begin kind = 2; code = 6'h02; end
         5'd12: begin kind = 2; code = 6'h03; end
         5'd13: begin kind = 3; code = 6'h08; end
         5'd14: begin kind = 3; code = 6'h09; end
         5'd15: begin kind = 3; code = 6'h0C; end
         5'd16: begin kind = 3; code = 6'h0D; end
         5'd17: begin kind = 3; code = 6'h0E; end
         5'd18: begin kind = 3; code = 6'h0A; end
         5'd19: begin kind = 3; code = 6'h0B; end
         5'd20: begin kind = 4; code = 6'h0F; end
         5'd21: begin kind = 3; code = 6'h23; end
         5'd22: begin kind = 3; code = 6'h2B; end
         5'd23: begin kind = 3; code = 6'h04; end
         5'd24: begin kind = 3; code = 6'h05; end
         5'd25: begin kind = 5; code = 6'h02; end
         default: kind = 0;
      endcase
      case (kind)
         1:       return {1'b1, 6'h00, rs, rt, rd, 5'h00, code};
         2:       return {1'b1, 6'h00, 5'h00, rt, rd, sh, code};
         3:       return {1'b1, code, rs, rt, imm};
         4:       return {1'b1, code, 5'h00, rt, imm};
         5:       return {1'b1, code, tgt};
         default: return 33'h0;
      endcase
   endfunction

   // Session model: expected outputs after each rising edge.
   bit          m_loading = 1'b0, m_we = 1'b0, m_done = 1'b0, m_err = 1'b0;
   logic [31:0] m_wdata = 32'h0, m_csum = 32'h0;
   int          m_count = 0;

   always @(posedge clk) begin : model_p
      logic [32:0] e;
      bit          ld, we, dn, er;
      logic [31:0] wd, cs;
      int          cnt;
      ld = m_loading; we = 1'b0; dn = m_done; er = m_err; wd = m_wdata; cs = m_csum;
      cnt = m_count;
      if (reset) begin
         ld = 1'b0; dn = 1'b0; er = 1'b0; wd = 32'h0; cs = 32'h0; cnt = 0;
      end else if (start) begin
         ld = 1'b1; dn = 1'b0; er = 1'b0; cs = 32'h0; cnt = 0;
      end else if (op_valid && ld) begin
         e = ref_enc(op_mnem, op_rs, op_rt, op_rd, op_shamt, op_imm, op_target);
         if (!e[32]) begin
            er = 1'b1; ld = 1'b0;
         end else begin
            we = 1'b1; wd = e[31:0]; cs = cs ^ e[31:0]; cnt = cnt + 1;
            if (op_last) begin
               dn = 1'b1; ld = 1'b0;
            end else if (cnt == int'(DEPTH)) begin
               er = 1'b1; ld = 1'b0;
            end
         end
      end
      m_loading <= ld; m_we <= we; m_done <= dn; m_err <= er;
      m_wdata <= wd; m_csum <= cs; m_count <= cnt;
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("op_ready", 32'(op_ready), 32'(m_loading && !start));
         check("imem_we", 32'(imem_we), 32'(m_we));
         check("imem_addr", imem_addr, BASE + 32'(4 * (m_count - int'(m_we))));
         check("imem_wdata", imem_wdata, m_wdata);
         check("word_count", 32'(word_count), 32'(m_count));
         check("done", 32'(done), 32'(m_done));
         check("err", 32'(err), 32'(m_err));
`ifdef INSTR_LOADER_CHECKSUM_EN
         check("checksum", checksum, m_csum);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      #1;
   endtask

   // Present a descriptor and wait (bounded) for the edge that accepts it.
   task automatic send(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic last);
      op_valid = 1'b1; op_mnem = mn; op_rs = rs; op_rt = rt; op_rd = rd; op_shamt = sh;
      op_imm = imm; op_target = tgt; op_last = last;
      for (int i = 0; i < 20; i++) begin
         if (op_ready) begin
            tick();
            return;
         end
         tick();
      end
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: op_ready stayed 0, required 1");
   endtask

   task automatic idle();
      op_valid = 1'b0;
      op_last  = 1'b0;
   endtask

   initial begin
      // reset state
      reset = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("rst_ready", 32'(op_ready), 32'd0);
      check("rst_we", 32'(imem_we), 32'd0);
      check("rst_addr", imem_addr, BASE);
      check("rst_wdata", imem_wdata, 32'h0);
      check("rst_count", 32'(word_count), 32'd0);
      tick();

      // 1: single ADD, write one cycle after accept
      pulse_start();
      send(MN_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
      check("t1_we", 32'(imem_we), 32'd1);
      check("t1_addr", imem_addr, BASE);
      check("t1_wdata", imem_wdata, 32'h0022_1820);
      idle();
      tick();

      // 2: back-to-back stream, op_last on the DEPTH-th word ends in done, not err
      pulse_start();
      send(MN_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b0);
      check("t2_w0", imem_wdata, 32'h2008_0005);
      check("t2_a0", imem_addr, BASE);
      send(MN_LW, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b0);
      check("t2_w1", imem_wdata, 32'h8FA8_0004);
      check("t2_a1", imem_addr, BASE + 32'h4);
      send(MN_BNE, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
      check("t2_w2", imem_wdata, 32'h1422_FFFF);
      check("t2_a2", imem_addr, BASE + 32'h8);
      send(MN_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1);
      check("t2_w3", imem_wdata, 32'h0800_0010);
      check("t2_a3", imem_addr, BASE + 32'hC);
      check("t2_done", 32'(done), 32'd1);
      check("t2_err", 32'(err), 32'd0);
`ifdef INSTR_LOADER_CHECKSUM_EN
      check("t2_csum", checksum, 32'hB382_FFEE);
`endif
      idle();
      tick();

      // 3: op_last on 3rd op; forced-zero fields; later op_valid ignored
      pulse_start();
      send(MN_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
      send(MN_SUB, 5'd1, 5'd2, 5'd4, 5'd5, 16'h0, 26'h0, 1'b0);
      check("t3_sub", imem_wdata, 32'h0022_2022);
      send(MN_SLL, 5'd7, 5'd6, 5'd5, 5'd4, 16'h0, 26'h0, 1'b1);
      check("t3_sll", imem_wdata, 32'h0006_2900);
      check("t3_done", 32'(done), 32'd1);
      check("t3_ready", 32'(op_ready), 32'd0);
      op_mnem = MN_ADD;
      op_last = 1'b0;
      repeat (3) tick();
      check("t3_count", 32'(word_count), 32'd3);
      check("t3_nowe", 32'(imem_we), 32'd0);
      idle();
      tick();

      // 4: overflow: DEPTH writes then err, extra op never accepted
      pulse_start();
      send(MN_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
      send(MN_ORI, 5'd2, 5'd3, 5'd0, 5'd0, 16'h00FF, 26'h0, 1'b0);
      check("t4_ori", imem_wdata, 32'h3443_00FF);
      send(MN_LUI, 5'd3, 5'd4, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0);
      check("t4_lui", imem_wdata, 32'h3C04_1234);
      send(MN_SW, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0008, 26'h0, 1'b0);
      check("t4_sw", imem_wdata, 32'hAFA8_0008);
      check("t4_we4", 32'(imem_we), 32'd1);
      check("t4_err", 32'(err), 32'd1);
      check("t4_count", 32'(word_count), 32'd4);
      op_mnem = MN_ADD;
      repeat (3) tick();
      check("t4_nowe", 32'(imem_we), 32'd0);
      check("t4_count2", 32'(word_count), 32'd4);
      idle();
      tick();

      // 5: illegal mnemonic accepted without write; start clears err
      pulse_start();
      send(5'h1F, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
      check("t5_nowe", 32'(imem_we), 32'd0);
      check("t5_err", 32'(err), 32'd1);
      check("t5_ready", 32'(op_ready), 32'd0);
      idle();
      tick();
      pulse_start();
      check("t5_clr", 32'(err), 32'd0);
      check("t5_addr", imem_addr, BASE);
      check("t5_ready2", 32'(op_ready), 32'd1);

      // 6: reset right after an accept kills the pending write and clears everything
      send(MN_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
      op_mnem = MN_SUB;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle();
      #1;
      check("t6_we", 32'(imem_we), 32'd0);
      check("t6_addr", imem_addr, BASE);
      check("t6_wdata", imem_wdata, 32'h0);
      check("t6_count", 32'(word_count), 32'd0);
      check("t6_ready", 32'(op_ready), 32'd0);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
